sine_pwm_sequencer: RTL and testbench

Controller that sequences the sine PWM datapath: owns the PWM period counter, fetches one sine sample per PWM period from the shared width look-up table over a req/ack handshake, and scales and clamps it. Presents a glitch-free `width` that changes only on period boundaries. Sits between the 300 MHz PLL clock domain's sample table and the counter/comparator that drives the `sine` pin, replacing free-running width generation with start/stop control and programmable frequency.

---
 rtl/sine_ctrl_pkg.sv | 16 +
 rtl/sine_pwm_sequencer_if.sv | 15 +
 rtl/pwm_period_counter.sv | 30 +++
 rtl/sine_pwm_sequencer.sv | 175 +++++++++++++++++
 tb/tb_sine_pwm_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sine_ctrl_pkg.sv
// Shared types and constants for the sine PWM sequencer: FSM state encoding and
// amplitude gain format (9-bit gain, 256 = unity).
package sine_ctrl_pkg;

   localparam int AMP_W      = 9;
   localparam int UNITY_GAIN = 256;
   localparam int GAIN_SHIFT = $clog2(UNITY_GAIN);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_SCALE,
      S_READY
   } seq_state_e;

endpackage

// File: rtl/sine_pwm_sequencer_if.sv
// Sample-table read port: request/address from the sequencer, ack/data from the table.
interface sine_pwm_sequencer_if #(
   parameter int ADDR_W   = 8,
   parameter int SAMPLE_W = 10
);

   logic                req;
   logic [ADDR_W-1:0]   addr;
   logic                ack;
   logic [SAMPLE_W-1:0] data;

   modport master (output req, output addr, input ack, input data);
   modport slave  (input req, input addr, output ack, output data);

endinterface

// File: rtl/pwm_period_counter.sv
// PWM period counter: counts 0..PERIOD-1 while enabled, held at 0 otherwise;
// tick marks the last cycle of each period.
module pwm_period_counter #(
   parameter int PERIOD = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   logic [CNT_W-1:0] count;

   assign tick = en && (count == CNT_W'(PERIOD - 1));

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!en || tick) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sine_pwm_sequencer.sv
// Sine PWM sequencer: fetches one table sample per PWM period, scales/clamps it and
// presents it as `width` on period boundaries. AMPLITUDE_SCALE_EN enables amplitude gain.
module sine_pwm_sequencer
   import sine_ctrl_pkg::*;
#(
   parameter int PERIOD   = 1000,
   parameter int ADDR_W   = 8,
   parameter int SAMPLE_W = 10,
   parameter int WIDTH_W  = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                stop,
   input  logic [ADDR_W-1:0]   phase_inc,
   input  logic [AMP_W-1:0]    amplitude,
   sine_pwm_sequencer_if.master lut,
   output logic                pwm_tick,
   output logic [WIDTH_W-1:0]  width,
   output logic                busy,
   output logic                underrun
);

   localparam int PROD_W = SAMPLE_W + AMP_W;

   seq_state_e          state;
   seq_state_e          next_state;
   logic [ADDR_W-1:0]   phase;
   logic [SAMPLE_W-1:0] sample_q;
   logic [WIDTH_W-1:0]  shadow;
   logic                shadow_valid;
   logic                stop_pending;
   logic                req;
   logic                do_start;
   logic                do_capture;
   logic                do_shadow;
   logic                do_load;
   logic                do_halt;
   logic                hold_stop;
   logic [PROD_W-1:0]   scaled;
   logic [WIDTH_W-1:0]  clamped;

   pwm_period_counter #(.PERIOD(PERIOD)) u_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (busy),
      .tick  (pwm_tick)
   );

   assign busy     = (state != S_IDLE);
   assign lut.req  = req;
   assign lut.addr = phase;
   assign underrun = pwm_tick && !shadow_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      next_state = state;
      req        = 1'b0;
      do_start   = 1'b0;
      do_capture = 1'b0;
      do_shadow  = 1'b0;
      do_load    = 1'b0;
      do_halt    = 1'b0;
      hold_stop  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start && !stop) begin
               do_start   = 1'b1;
               next_state = S_REQ;
            end
         end
         S_REQ: begin
            req = 1'b1;
            // A stop never abandons the handshake; the sample is dropped on ack.
            if (lut.ack) begin
               if (stop || stop_pending) begin
                  do_halt    = 1'b1;
                  next_state = S_IDLE;
               end else begin
                  do_capture = 1'b1;
                  next_state = S_SCALE;
               end
            end else if (stop) begin
               hold_stop = 1'b1;
            end
         end
         S_SCALE: begin
            if (stop) begin
               do_halt    = 1'b1;
               next_state = S_IDLE;
            end else begin
               do_shadow  = 1'b1;
               next_state = S_READY;
            end
         end
         S_READY: begin
            if (stop) begin
               do_halt    = 1'b1;
               next_state = S_IDLE;
            end else if (pwm_tick) begin
               do_load    = 1'b1;
               next_state = S_REQ;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

`ifdef AMPLITUDE_SCALE_EN
   always_comb begin
      scaled = PROD_W'((PROD_W'(sample_q) * PROD_W'(amplitude)) >> GAIN_SHIFT);
   end
`else
   logic unused_amplitude;
   assign unused_amplitude = ^amplitude;

   always_comb begin
      scaled = PROD_W'(sample_q);
   end
`endif

   always_comb begin
      if (64'(scaled) > 64'(PERIOD)) begin
         clamped = WIDTH_W'(PERIOD);
      end else begin
         clamped = WIDTH_W'(scaled);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase        <= '0;
         sample_q     <= '0;
         shadow       <= '0;
         shadow_valid <= 1'b0;
         stop_pending <= 1'b0;
         width        <= '0;
      end else begin
         if (do_start) begin
            phase <= '0;
         end
         if (do_capture) begin
            sample_q <= lut.data;
            phase    <= phase + phase_inc;
         end
         if (do_shadow) begin
            shadow       <= clamped;
            shadow_valid <= 1'b1;
         end
         if (do_load) begin
            width        <= shadow;
            shadow_valid <= 1'b0;
         end
         if (hold_stop) begin
            stop_pending <= 1'b1;
         end else if (state != S_REQ) begin
            stop_pending <= 1'b0;
         end
         if (do_halt) begin
            width        <= '0;
            shadow_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sine_pwm_sequencer.sv
// Directed bench for sine_pwm_sequencer: a delayed-ack table model answers reads,
// and immediate assertions compare outputs with hand-computed values.
module tb_sine_pwm_sequencer;

   localparam int PERIOD   = 1000;
   localparam int ADDR_W   = 8;
   localparam int SAMPLE_W = 10;
   localparam int WIDTH_W  = 32;

   logic                clk;
   logic                rst_n;
   logic                start;
   logic                stop;
   logic [ADDR_W-1:0]   phase_inc;
   logic [8:0]          amplitude;
   logic                pwm_tick;
   logic [WIDTH_W-1:0]  width;
   logic                busy;
   logic                underrun;

   sine_pwm_sequencer_if #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) lut_bus ();

   sine_pwm_sequencer #(
      .PERIOD   (PERIOD),
      .ADDR_W   (ADDR_W),
      .SAMPLE_W (SAMPLE_W),
      .WIDTH_W  (WIDTH_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .phase_inc (phase_inc),
      .amplitude (amplitude),
      .lut       (lut_bus),
      .pwm_tick  (pwm_tick),
      .width     (width),
      .busy      (busy),
      .underrun  (underrun)
   );

   int checks = 0;
   int failures = 0;

   // Table model settings, driven by the main sequence.
   int                  ack_delay = 2;
   bit                  data_mode = 1'b0;
   logic [SAMPLE_W-1:0] const_data = '0;
   int                  ack_count = 0;

   int tick_cnt = 0;
   int underrun_cnt = 0;
   int req_cnt = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      int wait_cnt;
      wait_cnt     = 0;
      lut_bus.ack  = 1'b0;
      lut_bus.data = '0;
      forever begin
         @(negedge clk);
         if (lut_bus.req && !lut_bus.ack) begin
            if (wait_cnt >= ack_delay) begin
               lut_bus.ack  = 1'b1;
               lut_bus.data = data_mode ? const_data : SAMPLE_W'(32'(lut_bus.addr) * 3);
               ack_count++;
            end
            wait_cnt++;
         end else begin
            lut_bus.ack = 1'b0;
            wait_cnt    = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (pwm_tick) tick_cnt++;
         if (underrun) underrun_cnt++;
         if (lut_bus.req) req_cnt++;
      end
   end

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Ends on the negedge inside the pwm_tick cycle.
   task automatic wait_tick(input string tag);
      for (int i = 0; i < 3 * PERIOD; i++) begin
         @(negedge clk);
         if (pwm_tick) break;
      end
      check({tag, "_seen"}, 64'(pwm_tick), 64'd1);
   endtask

   task automatic wait_req_low(input string tag);
      for (int i = 0; i < 2 * PERIOD; i++) begin
         if (!lut_bus.req) break;
         @(negedge clk);
      end
      check({tag, "_req_low"}, 64'(lut_bus.req), 64'd0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   initial begin
      int ur_base;
      int acks_before;
      int ticks_base;
      int reqs_base;

      rst_n     = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      phase_inc = 8'd1;
      amplitude = 9'd256;

      // Reset values, then a long idle stretch with no activity.
      step(2);
      check("rst_width", 64'(width), 64'd0);
      check("rst_req", 64'(lut_bus.req), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_tick", 64'(pwm_tick), 64'd0);
      rst_n = 1'b1;
      step(5000);
      check("idle_ticks", 64'(tick_cnt), 64'd0);
      check("idle_reqs", 64'(req_cnt), 64'd0);
      check("idle_width", 64'(width), 64'd0);

      // Table data = addr*3, ack 2 cycles after req, phase_inc 1.
      pulse_start();
      check("start_busy", 64'(busy), 64'd1);
      check("start_req", 64'(lut_bus.req), 64'd1);
      check("start_addr", 64'(lut_bus.addr), 64'd0);
      wait_tick("t1");
      step(1);
      check("w_t1", 64'(width), 64'd0);
      wait_tick("t2");
      step(1);
      check("w_t2", 64'(width), 64'd3);
      wait_tick("t3");
      step(1);
      check("w_t3", 64'(width), 64'd6);
      wait_tick("t4");
      step(1);
      check("w_t4", 64'(width), 64'd9);
      // Fetch of addr 4 is in flight: step phase to 255, then back to 1 to wrap.
      phase_inc = 8'd251;
      wait_req_low("wrap_a");
      phase_inc = 8'd1;
      wait_tick("t5");
      step(1);
      check("w_t5", 64'(width), 64'd12);
      check("addr_255", 64'(lut_bus.addr), 64'd255);
      wait_tick("t6");
      step(1);
      check("w_t6", 64'(width), 64'd765);
      check("addr_wrap", 64'(lut_bus.addr), 64'd0);
      wait_tick("t7");
      step(1);
      check("w_t7", 64'(width), 64'd0);
      check("no_underrun", 64'(underrun_cnt), 64'd0);

      // Stop while READY.
      wait_req_low("ready");
      step(3);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      check("stop_ready_busy", 64'(busy), 64'd0);
      check("stop_ready_width", 64'(width), 64'd0);
      check("stop_ready_req", 64'(lut_bus.req), 64'd0);

      // Slow table: first tick underruns, sample loads on the second tick.
      data_mode  = 1'b1;
      const_data = 10'd500;
      ack_delay  = 1200;
      ur_base    = underrun_cnt;
      pulse_start();
      wait_tick("u1");
      check("u1_underrun", 64'(underrun), 64'd1);
      step(1);
      check("u1_width", 64'(width), 64'd0);
      wait_req_low("slow_ack");
      ack_delay  = 2;
      const_data = 10'd1023;
      wait_tick("u2");
      check("u2_underrun", 64'(underrun), 64'd0);
      step(1);
      check("u2_width", 64'(width), 64'd500);
      wait_req_low("clamp_fetch");
      ack_delay = 10;
      wait_tick("u3");
      step(1);
      check("clamp_width", 64'(width), 64'd1000);
      check("underrun_once", 64'(underrun_cnt - ur_base), 64'd1);

      // Stop during REQ: request held until the ack, then IDLE.
      acks_before = ack_count;
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      check("stop_req_held", 64'(lut_bus.req), 64'd1);
      check("stop_req_busy", 64'(busy), 64'd1);
      wait_req_low("stop_req");
      check("stop_req_acked", 64'(ack_count - acks_before), 64'd1);
      check("stop_req_idle", 64'(busy), 64'd0);
      check("stop_req_width", 64'(width), 64'd0);

      // start and stop together while IDLE: stop wins.
      ack_delay = 2;
      start = 1'b1;
      stop  = 1'b1;
      step(1);
      start = 1'b0;
      stop  = 1'b0;
      check("both_busy", 64'(busy), 64'd0);
      check("both_req", 64'(lut_bus.req), 64'd0);

      // Amplitude run; a second start while busy must be ignored.
      const_data = 10'd600;
      amplitude  = 9'd128;
      pulse_start();
      wait_req_low("amp_first");
      step(3);
      pulse_start();
      check("restart_ignored", 64'(lut_bus.req), 64'd0);
      check("restart_busy", 64'(busy), 64'd1);
      wait_tick("a1");
      step(1);
`ifdef AMPLITUDE_SCALE_EN
      check("amp_half", 64'(width), 64'd300);
`else
      check("amp_half", 64'(width), 64'd600);
`endif
      check("amp_addr", 64'(lut_bus.addr), 64'd1);
      const_data = 10'd1000;
      amplitude  = 9'd511;
      wait_tick("a2");
      step(1);
      check("amp_clamp", 64'(width), 64'd1000);

      // Asynchronous reset mid-period while READY.
      wait_req_low("pre_reset");
      step(5);
      rst_n = 1'b0;
      #1;
      check("arst_width", 64'(width), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_req", 64'(lut_bus.req), 64'd0);
      check("arst_addr", 64'(lut_bus.addr), 64'd0);
      check("arst_underrun", 64'(underrun), 64'd0);
      step(1);
      rst_n = 1'b1;
      step(2);
      ticks_base = tick_cnt;
      reqs_base  = req_cnt;
      step(2000);
      check("post_rst_ticks", 64'(tick_cnt - ticks_base), 64'd0);
      check("post_rst_reqs", 64'(req_cnt - reqs_base), 64'd0);
      check("post_rst_busy", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
